keccak_digest_serializer: RTL and testbench



---
 rtl/keccak_pkg.sv | 24 ++
 rtl/keccak_order_convert.sv | 51 +++++
 rtl/keccak_digest_serializer.sv | 119 +++++++++++
 tb/tb_keccak_digest_serializer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/keccak_pkg.sv
`default_nettype none
// ============================================================================
// Package : keccak_pkg
// Purpose : Shared definitions for the Keccak digest output path: the
//           conversion-mode encodings and the serializer FSM state type.
// Ports   : none (package)
// Rev     : 1.0 - initial release
// ============================================================================
package keccak_pkg;

  // Conversion modes applied to a digest word
  localparam logic [1:0] MODE_PASS        = 2'd0;
  localparam logic [1:0] MODE_BITREV_BYTE = 2'd1;
  localparam logic [1:0] MODE_BYTEREV     = 2'd2;
  localparam logic [1:0] MODE_FULLREV     = 2'd3;

  // Serializer control states
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_e;

endpackage : keccak_pkg
`default_nettype wire

// File: rtl/keccak_order_convert.sv
`default_nettype none
// ============================================================================
// Module  : keccak_order_convert
// Purpose : Purely combinational bit/byte order conversion of a Keccak word.
//           Usable on both the squeeze (output) and absorb (input) paths.
// Ports   : d    - input word, DOUT_WIDTH bits
//           mode - conversion select (see keccak_pkg MODE_*)
//           c    - converted word, DOUT_WIDTH bits
// Rev     : 1.0 - initial release
// ============================================================================
module keccak_order_convert
  import keccak_pkg::*;
#(
  parameter int DOUT_WIDTH = 256
) (
  input  logic [DOUT_WIDTH-1:0] d,
  input  logic [1:0]            mode,
  output logic [DOUT_WIDTH-1:0] c
);

  localparam int NB = DOUT_WIDTH / 8;

  logic [DOUT_WIDTH-1:0] bitrev_byte;
  logic [DOUT_WIDTH-1:0] byterev;
  logic [DOUT_WIDTH-1:0] fullrev;

  // Every candidate ordering is pure wiring; only the final select is logic.
  for (genvar b = 0; b < NB; b++) begin : g_byte
    for (genvar k = 0; k < 8; k++) begin : g_bit
      assign bitrev_byte[8*b+k] = d[8*b+7-k];
      assign byterev[8*b+k]     = d[8*(NB-1-b)+k];
    end
  end

  for (genvar i = 0; i < DOUT_WIDTH; i++) begin : g_full
    assign fullrev[i] = d[DOUT_WIDTH-1-i];
  end

  always_comb begin
    c = d;
    case (mode)
      MODE_PASS:        c = d;
      MODE_BITREV_BYTE: c = bitrev_byte;
      MODE_BYTEREV:     c = byterev;
      MODE_FULLREV:     c = fullrev;
      default:          c = d;
    endcase
  end

endmodule : keccak_order_convert
`default_nettype wire

// File: rtl/keccak_digest_serializer.sv
`default_nettype none
// ============================================================================
// Module  : keccak_digest_serializer
// Purpose : Captures a full digest, converts its bit/byte order at accept
//           time and streams it out as OUT_WIDTH-bit words (word 0 first)
//           over a valid/ready handshake, with zero-bubble back-to-back
//           digests.
// Ports   : clk, rst            - clock, synchronous active-high reset
//           in_valid/in_ready   - digest input handshake
//           in_data, in_mode    - digest and conversion mode (sampled on accept)
//           out_valid/out_ready - word output handshake
//           out_data, out_last  - current word, high on the final word
// Rev     : 1.0 - initial release
// ============================================================================
module keccak_digest_serializer
  import keccak_pkg::*;
#(
  parameter int DOUT_WIDTH = 256,
  parameter int OUT_WIDTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DOUT_WIDTH-1:0] in_data,
  input  logic [1:0]            in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_last
);

  localparam int NUM_WORDS = DOUT_WIDTH / OUT_WIDTH;
  localparam int CW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_WORDS - 1);
  localparam logic          ONE_WORD = (NUM_WORDS == 1);

  ser_state_e            state_q;
  logic [DOUT_WIDTH-1:0] data_q;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         cnt_d;
  logic                  valid_q;
  logic                  last_q;
  logic [DOUT_WIDTH-1:0] conv_data;
  logic                  accept;

  keccak_order_convert #(
    .DOUT_WIDTH (DOUT_WIDTH)
  ) u_convert (
    .d    (in_data),
    .mode (in_mode),
    .c    (conv_data)
  );

  // A new digest may enter while idle, or in the very cycle the last word
  // of the current digest is handshaken (back-to-back with no bubble).
  assign in_ready = (state_q == ST_IDLE) ||
                    ((state_q == ST_SEND) && last_q && out_ready);
  assign accept   = in_valid && in_ready;
  assign cnt_d    = cnt_q + CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            data_q  <= conv_data;
            cnt_q   <= '0;
            valid_q <= 1'b1;
            last_q  <= ONE_WORD;
            state_q <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (out_ready) begin
            if (!last_q) begin
              cnt_q  <= cnt_d;
              last_q <= (cnt_d == LAST_IDX);
            end else if (accept) begin
              data_q  <= conv_data;
              cnt_q   <= '0;
              valid_q <= 1'b1;
              last_q  <= ONE_WORD;
            end else begin
              cnt_q   <= '0;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Word slices of the held, already-converted digest.
  logic [OUT_WIDTH-1:0] words [NUM_WORDS];
  for (genvar n = 0; n < NUM_WORDS; n++) begin : g_words
    assign words[n] = data_q[n*OUT_WIDTH +: OUT_WIDTH];
  end

  assign out_data  = words[cnt_q];
  assign out_valid = valid_q;
  assign out_last  = last_q;

endmodule : keccak_digest_serializer
`default_nettype wire

// File: tb/tb_keccak_digest_serializer.sv
`default_nettype none
// ============================================================================
// Module  : tb_keccak_digest_serializer
// Purpose : Self-checking bench for keccak_digest_serializer, using a small
//           32/16 instance for directed scenarios and a default 256/64
//           instance for randomized traffic against a reference model.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_keccak_digest_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // small instance: 32-bit digest, 16-bit words
  logic        s_in_valid = 1'b0, s_in_ready, s_out_valid, s_out_ready = 1'b0, s_out_last;
  logic [31:0] s_in_data = '0;
  logic [1:0]  s_in_mode = '0;
  logic [15:0] s_out_data;

  // wide instance: default 256-bit digest, 64-bit words
  logic         b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_out_last;
  logic [255:0] b_in_data = '0;
  logic [1:0]   b_in_mode = '0;
  logic [63:0]  b_out_data;

  keccak_digest_serializer #(.DOUT_WIDTH(32), .OUT_WIDTH(16)) u_small (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_mode(s_in_mode),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .out_last(s_out_last)
  );

  keccak_digest_serializer u_wide (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_mode(b_in_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_last(b_out_last)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference conversion: for each output bit, the source bit index follows
  // directly from the mode's definition.
  function automatic logic [255:0] model_conv(input logic [255:0] d, input int mode, input int w);
    logic [255:0] c;
    int nb, src;
    c  = '0;
    nb = w / 8;
    for (int i = 0; i < w; i++) begin
      case (mode)
        1:       src = 8 * (i / 8) + 7 - (i % 8);
        2:       src = 8 * (nb - 1 - i / 8) + (i % 8);
        3:       src = w - 1 - i;
        default: src = i;
      endcase
      c[i] = d[src];
    end
    return c;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_checks++; if (s_out_valid !== 1'b0) $display("FAIL reset_s_valid got %b exp 0", s_out_valid); else n_pass++;
    n_checks++; if (s_out_last  !== 1'b0) $display("FAIL reset_s_last got %b exp 0", s_out_last); else n_pass++;
    n_checks++; if (s_out_data  !== 16'h0) $display("FAIL reset_s_data got %h exp 0", s_out_data); else n_pass++;
    n_checks++; if (s_in_ready  !== 1'b1) $display("FAIL reset_s_in_ready got %b exp 1", s_in_ready); else n_pass++;
    n_checks++; if (b_out_valid !== 1'b0 || b_out_data !== 64'h0 || b_in_ready !== 1'b1)
      $display("FAIL reset_wide got valid=%b data=%h rdy=%b exp 0/0/1", b_out_valid, b_out_data, b_in_ready);
    else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  // Accept one digest on the small instance and check both words with
  // out_ready held high.
  task automatic small_digest(input logic [31:0] d, input logic [1:0] m,
                              input logic [15:0] w0, input logic [15:0] w1, input string nm);
    s_in_data = d; s_in_mode = m; s_in_valid = 1'b1; s_out_ready = 1'b1;
    tick();
    s_in_valid = 1'b0; s_in_mode = ~m; // later mode changes must not matter
    n_checks++; if (s_out_valid !== 1'b1 || s_out_data !== w0 || s_out_last !== 1'b0)
      $display("FAIL %s_w0 got v=%b d=%h l=%b exp 1/%h/0", nm, s_out_valid, s_out_data, s_out_last, w0);
    else n_pass++;
    tick();
    n_checks++; if (s_out_valid !== 1'b1 || s_out_data !== w1 || s_out_last !== 1'b1)
      $display("FAIL %s_w1 got v=%b d=%h l=%b exp 1/%h/1", nm, s_out_valid, s_out_data, s_out_last, w1);
    else n_pass++;
    tick();
    n_checks++; if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1)
      $display("FAIL %s_idle got v=%b rdy=%b exp 0/1", nm, s_out_valid, s_in_ready);
    else n_pass++;
  endtask

  task automatic test_modes();
    logic [31:0] d, c;
    logic [1:0]  m;
    small_digest(32'h12345678, 2'd0, 16'h5678, 16'h1234, "pass");
    small_digest(32'h12345678, 2'd1, 16'h6A1E, 16'h482C, "bitrev");
    small_digest(32'h12345678, 2'd2, 16'h3412, 16'h7856, "byterev");
    small_digest(32'h12345678, 2'd3, 16'h2C48, 16'h1E6A, "fullrev");
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      m = 2'(i);
      c = 32'(model_conv({224'h0, d}, i, 32));
      small_digest(d, m, c[15:0], c[31:16], "rand_small");
    end
  endtask

  task automatic test_backpressure();
    s_in_data = 32'h12345678; s_in_mode = 2'd0; s_in_valid = 1'b1; s_out_ready = 1'b1;
    tick();
    s_in_valid = 1'b0; s_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (s_out_valid !== 1'b1 || s_out_data !== 16'h5678 || s_out_last !== 1'b0)
        $display("FAIL bp_hold got v=%b d=%h l=%b exp 1/5678/0", s_out_valid, s_out_data, s_out_last);
      else n_pass++;
      tick();
    end
    s_out_ready = 1'b1;
    n_checks++; if (s_out_data !== 16'h5678) $display("FAIL bp_release got %h exp 5678", s_out_data); else n_pass++;
    tick();
    n_checks++; if (s_out_data !== 16'h1234 || s_out_last !== 1'b1)
      $display("FAIL bp_w1 got d=%h l=%b exp 1234/1", s_out_data, s_out_last);
    else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    s_in_data = 32'h12345678; s_in_mode = 2'd0; s_in_valid = 1'b1; s_out_ready = 1'b1;
    tick();
    s_in_data = 32'hAABBCCDD;
    n_checks++; if (s_out_data !== 16'h5678 || s_in_ready !== 1'b0)
      $display("FAIL b2b_w0 got d=%h rdy=%b exp 5678/0", s_out_data, s_in_ready);
    else n_pass++;
    tick();
    n_checks++; if (s_out_data !== 16'h1234 || s_out_last !== 1'b1 || s_in_ready !== 1'b1)
      $display("FAIL b2b_w1 got d=%h l=%b rdy=%b exp 1234/1/1", s_out_data, s_out_last, s_in_ready);
    else n_pass++;
    tick();
    s_in_valid = 1'b0;
    n_checks++; if (s_out_valid !== 1'b1 || s_out_data !== 16'hCCDD || s_out_last !== 1'b0)
      $display("FAIL b2b_w2 got v=%b d=%h l=%b exp 1/ccdd/0", s_out_valid, s_out_data, s_out_last);
    else n_pass++;
    tick();
    n_checks++; if (s_out_data !== 16'hAABB || s_out_last !== 1'b1)
      $display("FAIL b2b_w3 got d=%h l=%b exp aabb/1", s_out_data, s_out_last);
    else n_pass++;
    tick();
    n_checks++; if (s_out_valid !== 1'b0) $display("FAIL b2b_end got v=%b exp 0", s_out_valid); else n_pass++;
  endtask

  task automatic test_reset_midstream();
    s_in_data = 32'h12345678; s_in_mode = 2'd0; s_in_valid = 1'b1; s_out_ready = 1'b1;
    tick();
    s_in_valid = 1'b0;
    tick(); // word 0 handshaken on this edge
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (s_out_valid !== 1'b0 || s_out_last !== 1'b0 || s_out_data !== 16'h0 || s_in_ready !== 1'b1)
      $display("FAIL midrst got v=%b l=%b d=%h rdy=%b exp 0/0/0000/1", s_out_valid, s_out_last, s_out_data, s_in_ready);
    else n_pass++;
    small_digest(32'hCAFEF00D, 2'd2, 16'hFECA, 16'h0DF0, "after_rst");
  endtask

  task automatic test_random_wide();
    logic [255:0] d, c;
    int m, stall;
    for (int t = 0; t < 6; t++) begin
      for (int j = 0; j < 8; j++) d[32*j +: 32] = $urandom;
      m = (t < 3) ? 1 : int'($urandom_range(0, 3));
      c = model_conv(d, m, 256);
      b_in_data = d; b_in_mode = 2'(m); b_in_valid = 1'b1; b_out_ready = 1'b1;
      tick();
      b_in_valid = 1'b0; b_in_data = ~d;
      for (int w = 0; w < 4; w++) begin
        stall = int'($urandom_range(0, 2));
        b_out_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
          n_checks++; if (b_out_valid !== 1'b1 || b_out_data !== c[64*w +: 64])
            $display("FAIL wide_hold w%0d got v=%b d=%h exp 1/%h", w, b_out_valid, b_out_data, c[64*w +: 64]);
          else n_pass++;
          tick();
        end
        b_out_ready = 1'b1;
        n_checks++; if (b_out_valid !== 1'b1 || b_out_data !== c[64*w +: 64] || b_out_last !== (w == 3))
          $display("FAIL wide_word w%0d got v=%b d=%h l=%b exp 1/%h/%b", w, b_out_valid, b_out_data, b_out_last,
                   c[64*w +: 64], (w == 3));
        else n_pass++;
        tick();
      end
      n_checks++; if (b_out_valid !== 1'b0) $display("FAIL wide_idle got v=%b exp 0", b_out_valid); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_backpressure();
    test_back_to_back();
    test_reset_midstream();
    test_random_wide();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_keccak_digest_serializer
`default_nettype wire
